simple_ram: RTL and testbench

SIMPLE_RAM -- requirements
Module: simple_ram

---
 rtl/simple_ram.sv | 49 ++++
 tb/tb_simple_ram.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/simple_ram.sv
// Single-port synchronous RAM with registered, write-through read data.
// Contents survive reset; only the output register is cleared.
module simple_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [31:0]           addr,
  input  logic                  wr,
  input  logic                  enable,
  output logic [DATA_WIDTH-1:0] q
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Zero-initialised so never-written words read back as 0.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
  logic [ADDR_WIDTH-1:0] index;
  logic                  access;

  assign index  = addr[ADDR_WIDTH-1:0];
  assign access = enable && !rst;

  // Upper address bits alias onto the same words and are intentionally ignored.
  generate
    if (ADDR_WIDTH < 32) begin : g_addr_alias
      logic unused_addr_bits;
      assign unused_addr_bits = ^addr[31:ADDR_WIDTH];
    end
  endgenerate

  // Memory array has no reset so the contents are retained across rst.
  always_ff @(posedge clk) begin
    if (access && wr) begin
      mem[index] <= data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (enable) begin
      q <= wr ? data : mem[index];
    end
  end

endmodule

// File: tb/tb_simple_ram.sv
// Self-checking bench for simple_ram: directed vector table, reset/retention
// sequences, and randomized traffic against an array-based reference model.
module tb_simple_ram;

  logic        clk;
  logic        rst;
  logic [31:0] data;
  logic [31:0] addr;
  logic        wr;
  logic        enable;
  logic [31:0] q;

  int checks;
  int failures;

  logic [31:0] model_mem [256];
  logic [31:0] model_q;

  typedef struct {
    string       name;
    logic        enable;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_q;
  } vector_t;

  vector_t vectors [$];

  simple_ram #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .data   (data),
    .addr   (addr),
    .wr     (wr),
    .enable (enable),
    .q      (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] expected);
    checks++;
    if (q !== expected) begin
      failures++;
      $display("[TB] FAIL %s: q=%08h expected=%08h at %0t", name, q, expected, $time);
    end
  endtask

  // Drives one request at the falling edge, clocks it in, and updates the model.
  task automatic applyStimulus(input logic en_i, input logic wr_i,
                               input logic [31:0] addr_i, input logic [31:0] data_i,
                               input logic rst_i);
    @(negedge clk);
    enable = en_i;
    wr     = wr_i;
    addr   = addr_i;
    data   = data_i;
    rst    = rst_i;
    @(posedge clk);
    #1;
    if (rst_i) begin
      model_q = 32'h0;
    end else if (en_i) begin
      if (wr_i) begin
        model_mem[addr_i % 256] = data_i;
        model_q = data_i;
      end else begin
        model_q = model_mem[addr_i % 256];
      end
    end
  endtask

  task automatic addVector(input string n, input logic e, input logic w,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] x);
    vector_t v;
    v.name = n; v.enable = e; v.wr = w; v.addr = a; v.data = d; v.exp_q = x;
    vectors.push_back(v);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_q  = 32'h0;
    for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;

    rst = 1'b1; enable = 1'b0; wr = 1'b0; addr = 32'h0; data = 32'h0;
    #12;
    checkOutput("reset_state", 32'h0);

    addVector("write_through_5",  1, 1, 32'd5,          32'hCAFEF00D, 32'hCAFEF00D);
    addVector("read_5",           1, 0, 32'd5,          32'h0,        32'hCAFEF00D);
    addVector("alias_write_103",  1, 1, 32'h00000103,   32'h11111111, 32'h11111111);
    addVector("alias_read_3",     1, 0, 32'h00000003,   32'hFFFFFFFF, 32'h11111111);
    addVector("read_unwritten",   1, 0, 32'd200,        32'h0,        32'h0);
    addVector("read_5_again",     1, 0, 32'd5,          32'h0,        32'hCAFEF00D);
    addVector("hold_0",           0, 1, 32'd5,          32'h0,        32'hCAFEF00D);
    addVector("hold_1",           0, 1, 32'd5,          32'h0,        32'hCAFEF00D);
    addVector("hold_2",           0, 1, 32'd5,          32'h0,        32'hCAFEF00D);
    addVector("hold_then_read_5", 1, 0, 32'd5,          32'h0,        32'hCAFEF00D);
    addVector("high_alias_read",  1, 0, 32'hFFFFFF05,   32'h0,        32'hCAFEF00D);
    for (int i = 0; i < 4; i++)
      addVector($sformatf("burst_write_%0d", i), 1, 1, i, 32'hA0 + i, 32'hA0 + i);
    for (int i = 0; i < 4; i++)
      addVector($sformatf("burst_read_%0d", i), 1, 0, i, 32'h0, 32'hA0 + i);
    addVector("read_before_write", 1, 0, 32'd7,  32'h0,        32'h0);
    addVector("write_7",           1, 1, 32'd7,  32'h77777777, 32'h77777777);
    addVector("read_after_write",  1, 0, 32'd7,  32'h0,        32'h77777777);

    @(negedge clk);
    rst = 1'b0;
    foreach (vectors[i]) begin
      applyStimulus(vectors[i].enable, vectors[i].wr, vectors[i].addr, vectors[i].data, 1'b0);
      checkOutput(vectors[i].name, vectors[i].exp_q);
    end

    // Mid-run async reset, dropped request during reset, and retention afterwards.
    applyStimulus(1, 1, 32'd9,  32'h12345678, 1'b0);
    applyStimulus(1, 1, 32'd10, 32'hDEADBEEF, 1'b0);
    checkOutput("pre_reset_q", 32'hDEADBEEF);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("async_reset_no_clock", 32'h0);
    applyStimulus(1, 1, 32'd10, 32'h55555555, 1'b1);
    checkOutput("request_during_reset", 32'h0);
    applyStimulus(1, 0, 32'd9, 32'h0, 1'b0);
    checkOutput("retention_9", 32'h12345678);
    applyStimulus(1, 0, 32'd10, 32'h0, 1'b0);
    checkOutput("dropped_write_10", 32'hDEADBEEF);
    applyStimulus(1, 0, 32'd200, 32'h0, 1'b0);
    checkOutput("unwritten_200_after_reset", 32'h0);

    // Random traffic over a small address window so reads hit written words.
    for (int n = 0; n < 400; n++) begin
      logic        r_en, r_wr, r_rst;
      logic [31:0] r_addr, r_data;
      r_en   = ($urandom_range(0, 3) != 0);
      r_wr   = $urandom_range(0, 1) == 1;
      r_addr = ($urandom() & 32'hFFFFFF00) | 32'($urandom_range(0, 15));
      r_data = $urandom();
      r_rst  = ($urandom_range(0, 40) == 0);
      applyStimulus(r_en, r_wr, r_addr, r_data, r_rst);
      checkOutput($sformatf("random_%0d", n), model_q);
    end

    // Sweep the random window back to confirm final contents.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 0, 32'(i), 32'h0, 1'b0);
      checkOutput($sformatf("final_read_%0d", i), model_mem[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
